// File: rtl/cp0_vec_int_ctrl.sv
// cp0_vec_int_ctrl: CP0 exception/interrupt controller for the 5-stage MIPS pipeline.
// Owns STATUS/CAUSE/EPC, raises sticky, maskable, fixed-priority vectored interrupts,
// handles synchronous exceptions (RI, Ov, syscall) and eret, and drives the trap PC
// and pipeline flush for the instruction currently in EX.
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   irq[N_IRQ]                 asynchronous level interrupt requests
//   cr_read/cr_write/cr_addr   mfc0/mtc0 in EX (12 STATUS, 13 CAUSE, 14 EPC)
//   cr_wdata / cr_rdata        mtc0 data in, mfc0 data out (combinational)
//   ex_pc, ex_valid            EX-stage PC and non-bubble flag
//   exc_ri/exc_ov/syscall/eret EX-stage event flags
//   pipe_ready                 pipeline not stalled; redirect allowed this cycle
//   redirect/new_pc/flush      combinational PC redirect and pipeline flush
//   irq_ack[N_IRQ]             one-hot pulse for the interrupt channel taken
//   in_handler                 STATUS.EXL
// N_IRQ must be 1..16; IM/IP for channel k live at bit 8+k of STATUS/CAUSE.
module cp0_vec_int_ctrl #(
  parameter int unsigned N_IRQ      = 8,
  parameter logic [31:0] VEC_EXC    = 32'h0000_0008,
  parameter logic [31:0] VEC_INT    = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             cr_read,
  input  logic             cr_write,
  input  logic [4:0]       cr_addr,
  input  logic [31:0]      cr_wdata,
  output logic [31:0]      cr_rdata,
  input  logic [31:0]      ex_pc,
  input  logic             ex_valid,
  input  logic             exc_ri,
  input  logic             exc_ov,
  input  logic             syscall,
  input  logic             eret,
  input  logic             pipe_ready,
  output logic             redirect,
  output logic [31:0]      new_pc,
  output logic             flush,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             in_handler
);

  localparam int unsigned CODE_W = 5;
  localparam int unsigned IM_LSB = 8;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  localparam logic [CODE_W-1:0] EXC_INT = CODE_W'(0);
  localparam logic [CODE_W-1:0] EXC_SYS = CODE_W'(8);
  localparam logic [CODE_W-1:0] EXC_RI  = CODE_W'(10);
  localparam logic [CODE_W-1:0] EXC_OV  = CODE_W'(12);

  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

  state_t             state_q, state_n;
  logic               ie_q, ie_n;
  logic [N_IRQ-1:0]   im_q, im_n;
  logic [N_IRQ-1:0]   ip_q, ip_n;
  logic [31:0]        epc_q, epc_n;
  logic [CODE_W-1:0]  code_q, code_n;
  logic [N_IRQ-1:0]   sync1_q, sync2_q, sync3_q;

  logic [N_IRQ-1:0]   irq_rise;
  logic [N_IRQ-1:0]   pending;
  logic [N_IRQ-1:0]   int_sel;
  logic [N_IRQ-1:0]   ip_clr;
  logic [31:0]        int_pc;
  logic               int_ok;
  logic               take_evt;
  logic               is_exc;
  logic               wr_en;
  logic [31:0]        status_w, cause_w;

  // Two-flop synchroniser plus a third flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign irq_rise = sync2_q & ~sync3_q;

  // State register and CP0 architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      ie_q    <= 1'b0;
      im_q    <= '0;
      ip_q    <= '0;
      epc_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_n;
      ie_q    <= ie_n;
      im_q    <= im_n;
      ip_q    <= ip_n;
      epc_q   <= epc_n;
      code_q  <= code_n;
    end
  end

  // Lowest-index eligible channel and its vector.
  always_comb begin
    int_sel = '0;
    int_pc  = VEC_INT;
    pending = ip_q & im_q;
    for (int k = int'(N_IRQ) - 1; k >= 0; k--) begin
      if (pending[k]) begin
        int_sel    = '0;
        int_sel[k] = 1'b1;
        int_pc     = VEC_INT + 32'(k) * VEC_STRIDE;
      end
    end
  end

  assign int_ok   = ie_q && (state_q == RUN) && (|pending);
  assign take_evt = reset && ex_valid && pipe_ready;
  // eret outside a handler is reported as a reserved instruction.
  assign is_exc   = exc_ri || exc_ov || syscall || (eret && (state_q == RUN));

  // Next-state, register update and Mealy trap outputs.
  always_comb begin
    state_n  = state_q;
    ie_n     = ie_q;
    im_n     = im_q;
    epc_n    = epc_q;
    code_n   = code_q;
    ip_clr   = '0;
    redirect = 1'b0;
    flush    = 1'b0;
    new_pc   = '0;
    irq_ack  = '0;
    wr_en    = 1'b0;

    if (take_evt) begin
      if (is_exc) begin
        redirect = 1'b1;
        flush    = 1'b1;
        new_pc   = VEC_EXC;
        if (exc_ri)       code_n = EXC_RI;
        else if (exc_ov)  code_n = EXC_OV;
        else if (syscall) code_n = EXC_SYS;
        else              code_n = EXC_RI;
        // A nested exception keeps the original return address.
        if (state_q == RUN) begin
          state_n = HANDLER;
          epc_n   = (!exc_ri && !exc_ov && syscall) ? ex_pc + 32'd4 : ex_pc;
        end
      end else if (eret) begin
        redirect = 1'b1;
        flush    = 1'b1;
        new_pc   = epc_q;
        state_n  = RUN;
      end else if (int_ok) begin
        redirect = 1'b1;
        flush    = 1'b1;
        new_pc   = int_pc;
        irq_ack  = int_sel;
        epc_n    = ex_pc;
        code_n   = EXC_INT;
        state_n  = HANDLER;
      end
    end

    // The mtc0 is flushed along with the EX instruction on a redirect.
    wr_en = reset && cr_write && !redirect;
    if (wr_en) begin
      case (cr_addr)
        ADDR_STATUS: begin
          ie_n    = cr_wdata[0];
          state_n = cr_wdata[1] ? HANDLER : RUN;
          im_n    = cr_wdata[IM_LSB +: N_IRQ];
        end
        ADDR_CAUSE: ip_clr = ~cr_wdata[IM_LSB +: N_IRQ];
        ADDR_EPC:   epc_n  = cr_wdata;
        default: ;
      endcase
    end

    // A new edge wins over a simultaneous clear.
    ip_n = (ip_q & ~irq_ack & ~ip_clr) | irq_rise;
  end

  // mfc0 read mux.
  always_comb begin
    status_w                     = '0;
    status_w[0]                  = ie_q;
    status_w[1]                  = (state_q == HANDLER);
    status_w[IM_LSB +: N_IRQ]    = im_q;
    cause_w                      = '0;
    cause_w[IM_LSB +: N_IRQ]     = ip_q;
    cause_w[6:2]                 = code_q;
    cr_rdata                     = '0;
    if (reset && cr_read) begin
      case (cr_addr)
        ADDR_STATUS: cr_rdata = status_w;
        ADDR_CAUSE:  cr_rdata = cause_w;
        ADDR_EPC:    cr_rdata = epc_q;
        default:     cr_rdata = '0;
      endcase
    end
  end

  assign in_handler = (state_q == HANDLER);

endmodule
